// File: rtl/rotary_encoder_arb_pkg.sv
// -----------------------------------------------------------------------------
// rotary_encoder_arb_pkg
//   Shared types and width helpers for the rotary encoder arbiter.
//   - arb_state_t : arbiter FSM states (IDLE, LOAD, SETTLE, OWN, SAVE)
//   - idx_w(n)    : bits needed to index n entries (minimum 1)
//   - cnt_w(n)    : bits needed to hold the values 0..n
// -----------------------------------------------------------------------------
package rotary_encoder_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    OWN    = 3'd3,
    SAVE   = 3'd4
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
//   Combinational round-robin picker: returns the first asserted request at or
//   after rr_ptr, wrapping around NUM_CH channels.
//   Ports:
//     req     in   NUM_CH   request vector
//     rr_ptr  in   CH_W     channel with highest priority this round
//     valid   out  1        at least one request is asserted
//     index   out  CH_W     winning channel (0 when valid is low)
// -----------------------------------------------------------------------------
module rr_priority_picker
  import rotary_encoder_arb_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]        req,
  input  logic [idx_w(NUM_CH)-1:0] rr_ptr,
  output logic                     valid,
  output logic [idx_w(NUM_CH)-1:0] index
);

  localparam int CH_W = idx_w(NUM_CH);

  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      int c;
      c = (int'(rr_ptr) + k) % NUM_CH;
      if (!valid && req[c]) begin
        valid = 1'b1;
        index = CH_W'(c);
      end
    end
  end

endmodule

// File: rtl/rotary_encoder_arbiter.sv
// -----------------------------------------------------------------------------
// rotary_encoder_arbiter
//   Shares one rotary encoder counter among NUM_CH requesters. Each requester
//   owns a saved value in a bank; on grant the value is loaded into the encoder
//   counter, on release the counter is captured back into the bank.
//   Optional build macro: ROTARY_ARB_TIMEOUT_EN (forced release after
//   TIMEOUT_CYCLES cycles without encoder counter change; timed-out channel is
//   masked until its req goes low).
//   Ports:
//     clk               in   1             system clock
//     reset_n           in   1             asynchronous, active-low reset
//     req               in   NUM_CH        level request per channel
//     grant             out  NUM_CH        one-hot ownership, registered
//     enc_counter_init  out  1             load pulse to the encoder counter
//     enc_counter_in    out  COUNTER_BITS  load value to the encoder counter
//     enc_counter_out   in   COUNTER_BITS  live encoder counter value
//     rd_ch             in   $clog2(NUM_CH) read-port channel select
//     rd_value          out  COUNTER_BITS  value of channel rd_ch (combinational)
//     busy              out  1             high in LOAD/SETTLE/SAVE
// -----------------------------------------------------------------------------
module rotary_encoder_arbiter
  import rotary_encoder_arb_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int COUNTER_BITS   = 8,
  parameter int INIT_VALUE     = 0,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_CH-1:0]         req,
  output logic [NUM_CH-1:0]         grant,
  output logic                      enc_counter_init,
  output logic [COUNTER_BITS-1:0]   enc_counter_in,
  input  logic [COUNTER_BITS-1:0]   enc_counter_out,
  input  logic [$clog2(NUM_CH)-1:0] rd_ch,
  output logic [COUNTER_BITS-1:0]   rd_value,
  output logic                      busy
);

  localparam int CH_W = idx_w(NUM_CH);

  arb_state_t              state, state_nxt;
  logic [CH_W-1:0]         owner;
  logic [CH_W-1:0]         rr_ptr;
  logic [NUM_CH-1:0]       owner_oh;
  logic [COUNTER_BITS-1:0] bank [NUM_CH];
  logic [COUNTER_BITS-1:0] rd_bank;
  logic [NUM_CH-1:0]       req_eff;
  logic                    pick_valid;
  logic [CH_W-1:0]         pick_idx;
  logic                    timeout_hit;

  assign owner_oh = NUM_CH'(1) << owner;

  rr_priority_picker #(
    .NUM_CH (NUM_CH)
  ) u_picker (
    .req    (req_eff),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .index  (pick_idx)
  );

`ifdef ROTARY_ARB_TIMEOUT_EN
  localparam int TO_W = cnt_w(TIMEOUT_CYCLES);

  logic [TO_W-1:0]         idle_cnt;
  logic [COUNTER_BITS-1:0] enc_prev;
  logic [NUM_CH-1:0]       to_mask;

  // Counter measures consecutive OWN cycles without any encoder counter change.
  assign timeout_hit = (state == OWN) && (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign req_eff     = req & ~to_mask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt <= '0;
      enc_prev <= '0;
      to_mask  <= '0;
    end else begin
      enc_prev <= enc_counter_out;
      if ((state != OWN) || (enc_counter_out != enc_prev))
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + 1'b1;
      // A mask bit survives only while its req stays high; one low cycle clears it.
      to_mask <= (to_mask & req) | (timeout_hit ? owner_oh : '0);
    end
  end
`else
  // Timeout compiled out: release happens only through a req drop.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
  assign req_eff     = req;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      grant  <= '0;
      for (int i = 0; i < NUM_CH; i++)
        bank[i] <= COUNTER_BITS'(INIT_VALUE);
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && pick_valid)
        owner <= pick_idx;
      grant <= (state_nxt == OWN) ? owner_oh : '0;
      if (state == SAVE) begin
        bank[owner] <= enc_counter_out;
        rr_ptr      <= (owner == CH_W'(NUM_CH - 1)) ? '0 : owner + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    enc_counter_init = 1'b0;
    enc_counter_in   = bank[owner];
    busy             = 1'b0;
    unique case (state)
      IDLE:   if (pick_valid) state_nxt = LOAD;
      LOAD: begin
        enc_counter_init = 1'b1;
        busy             = 1'b1;
        state_nxt        = SETTLE;
      end
      SETTLE: begin
        busy      = 1'b1;
        state_nxt = OWN;
      end
      OWN:    if (!req[owner] || timeout_hit) state_nxt = SAVE;
      SAVE: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Out-of-range rd_ch matches no bank entry and reads back zero.
  always_comb begin
    rd_bank = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (rd_ch == CH_W'(i)) rd_bank = bank[i];
  end

  assign rd_value = ((state == OWN) && (rd_ch == owner)) ? enc_counter_out : rd_bank;

endmodule
